hot_addr_responder: RTL and testbench

HOT_ADDR_RESPONDER -- requirements
Module: hot_addr_responder

---
 rtl/page_hotness_pkg.sv | 29 ++
 rtl/hot_topk_list.sv | 86 ++++++++
 rtl/hot_addr_responder.sv | 89 ++++++++
 tb/tb_hot_addr_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/page_hotness_pkg.sv
// Shared types for the page-hotness blocks: query opcodes and the
// hot-table entry. Entry fields are sized to the widest supported block.
package page_hotness_pkg;

  localparam int HOT_ADDR_MAX = 64;
  localparam int HOT_CNT_MAX  = 32;

  localparam int QUERY_IDLE  = 0;
  localparam int QUERY_MIG   = 1;
  localparam int QUERY_FLUSH = 2;

  typedef struct packed {
    logic                    valid;
    logic [HOT_ADDR_MAX-1:0] addr;
    logic [HOT_CNT_MAX-1:0]  cnt;
  } hot_entry_t;

  function automatic hot_entry_t hot_entry(
    input logic [HOT_ADDR_MAX-1:0] addr,
    input logic [HOT_CNT_MAX-1:0]  cnt
  );
    hot_entry_t e;
    e.valid = 1'b1;
    e.addr  = addr;
    e.cnt   = cnt;
    return e;
  endfunction

endpackage

// File: rtl/hot_topk_list.sv
// Sorted top-K table (descending cnt, valid entries packed from 0).
// Ports: clr/upd/pop commands, head_addr, head_valid_nxt (entry0 after edge).
module hot_topk_list
  import page_hotness_pkg::*;
#(
  parameter int TOP_K     = 5,
  parameter int ADDR_SIZE = 28,
  parameter int CNT_SIZE  = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 upd,
  input  logic [ADDR_SIZE-1:0] upd_addr,
  input  logic [CNT_SIZE-1:0]  upd_cnt,
  input  logic                 pop,
  output logic [ADDR_SIZE-1:0] head_addr,
  output logic                 head_valid_nxt
);

  hot_entry_t tbl [TOP_K];
  hot_entry_t up  [TOP_K];
  hot_entry_t rem [TOP_K];
  hot_entry_t dn  [TOP_K];
  hot_entry_t ins [TOP_K];
  hot_entry_t d   [TOP_K];
  hot_entry_t new_e;
  logic       hit;
  logic       placed;

  // Invalid slots are kept all-zero, so an empty table reads addr 0.
  always_comb begin
    new_e = hot_entry(HOT_ADDR_MAX'(upd_addr), HOT_CNT_MAX'(upd_cnt));
    for (int i = 0; i < TOP_K; i++) begin
      up[i]  = '0;
      rem[i] = '0;
      dn[i]  = '0;
      ins[i] = '0;
      d[i]   = '0;
    end
    for (int i = 0; i < TOP_K - 1; i++) begin
      up[i] = tbl[i+1];
    end
    // Remove a matching entry by closing the gap.
    hit = 1'b0;
    for (int i = 0; i < TOP_K; i++) begin
      if (tbl[i].valid && tbl[i].addr == new_e.addr) hit = 1'b1;
      rem[i] = hit ? up[i] : tbl[i];
    end
    for (int i = 1; i < TOP_K; i++) begin
      dn[i] = rem[i-1];
    end
    // Strict less-than keeps older equal-count entries ahead.
    placed = 1'b0;
    for (int i = 0; i < TOP_K; i++) begin
      if (placed) begin
        ins[i] = dn[i];
      end else if (!rem[i].valid || rem[i].cnt < new_e.cnt) begin
        ins[i] = new_e;
        placed = 1'b1;
      end else begin
        ins[i] = rem[i];
      end
    end
    for (int i = 0; i < TOP_K; i++) begin
      unique case (1'b1)
        clr:     d[i] = '0;
        pop:     d[i] = up[i];
        upd:     d[i] = ins[i];
        default: d[i] = tbl[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TOP_K; i++) tbl[i] <= '0;
    end else begin
      for (int i = 0; i < TOP_K; i++) tbl[i] <= d[i];
    end
  end

  assign head_addr      = tbl[0].addr[ADDR_SIZE-1:0];
  assign head_valid_nxt = d[0].valid;

endmodule

// File: rtl/hot_addr_responder.sv
// Hot-address responder: keeps a top-K table, drains it on MIG, counts
// updates dropped while draining. query/mig handshakes, drop_cnt output.
module hot_addr_responder
  import page_hotness_pkg::*;
#(
  parameter int TOP_K     = 5,
  parameter int ADDR_SIZE = 28,
  parameter int CNT_SIZE  = 13,
  parameter int CMD_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd_en,
  input  logic [ADDR_SIZE-1:0] upd_addr,
  input  logic [CNT_SIZE-1:0]  upd_cnt,
  input  logic                 query_en,
  input  logic [CMD_WIDTH-1:0] query_cmd,
  output logic                 query_ready,
  output logic                 mig_addr_en,
  output logic [ADDR_SIZE-1:0] mig_addr,
  input  logic                 mig_addr_ready,
  output logic [15:0]          drop_cnt
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t state;
  state_t state_n;
  logic   idle;
  logic   accept;
  logic   do_mig;
  logic   do_flush;
  logic   do_upd;
  logic   do_pop;
  logic   head_valid_nxt;

  assign idle     = (state == IDLE);
  assign accept   = query_en && idle;
  assign do_mig   = accept &&
                    (query_cmd == CMD_WIDTH'(QUERY_MIG));
  assign do_flush = accept &&
                    (query_cmd == CMD_WIDTH'(QUERY_FLUSH));
  assign do_upd   = upd_en && idle && !do_flush;
  assign do_pop   = !idle && mig_addr_ready;

  hot_topk_list #(
    .TOP_K    (TOP_K),
    .ADDR_SIZE(ADDR_SIZE),
    .CNT_SIZE (CNT_SIZE)
  ) u_list (
    .clk           (clk),
    .rst           (rst),
    .clr           (do_flush),
    .upd           (do_upd),
    .upd_addr      (upd_addr),
    .upd_cnt       (upd_cnt),
    .pop           (do_pop),
    .head_addr     (mig_addr),
    .head_valid_nxt(head_valid_nxt)
  );

  // head_valid_nxt already includes this edge's update or pop.
  always_comb begin
    state_n = state;
    unique case (1'b1)
      state == IDLE:
        if (do_mig && head_valid_nxt) state_n = DRAIN;
      state == DRAIN:
        if (do_pop && !head_valid_nxt) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      query_ready <= 1'b1;
      mig_addr_en <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_n;
      query_ready <= (state_n == IDLE);
      mig_addr_en <= (state_n == DRAIN);
      if (!idle && upd_en && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hot_addr_responder.sv
// Directed bench for hot_addr_responder with a queue-based reference
// model checked every cycle plus literal expectations per scenario.
module tb_hot_addr_responder;

  localparam int K  = 5;
  localparam int AW = 28;
  localparam int CW = 13;
  localparam int QW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          upd_en = 1'b0;
  logic [AW-1:0] upd_addr = '0;
  logic [CW-1:0] upd_cnt = '0;
  logic          query_en = 1'b0;
  logic [QW-1:0] query_cmd = '0;
  logic          query_ready;
  logic          mig_addr_en;
  logic [AW-1:0] mig_addr;
  logic          mig_addr_ready = 1'b0;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  hot_addr_responder #(
    .TOP_K(K), .ADDR_SIZE(AW), .CNT_SIZE(CW), .CMD_WIDTH(QW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .upd_en        (upd_en),
    .upd_addr      (upd_addr),
    .upd_cnt       (upd_cnt),
    .query_en      (query_en),
    .query_cmd     (query_cmd),
    .query_ready   (query_ready),
    .mig_addr_en   (mig_addr_en),
    .mig_addr      (mig_addr),
    .mig_addr_ready(mig_addr_ready),
    .drop_cnt      (drop_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: sorted list of (addr,cnt), front is hottest.
  typedef struct {
    logic [AW-1:0] a;
    logic [CW-1:0] c;
  } m_ent_t;

  m_ent_t mq[$];
  bit     m_drain = 0;
  int     m_drop  = 0;

  task automatic m_update(input logic [AW-1:0] a, input logic [CW-1:0] c);
    int pos;
    m_ent_t e;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].a == a) begin
        mq.delete(i);
        break;
      end
    end
    pos = mq.size();
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].c < c) begin
        pos = i;
        break;
      end
    end
    if (pos < K) begin
      e.a = a;
      e.c = c;
      mq.insert(pos, e);
      if (mq.size() > K) void'(mq.pop_back());
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_drain = 0;
      m_drop  = 0;
    end else if (!m_drain) begin
      if (query_en && query_cmd == 4'd2) mq.delete();
      else if (upd_en) m_update(upd_addr, upd_cnt);
      if (query_en && query_cmd == 4'd1 && mq.size() > 0) m_drain = 1;
    end else begin
      if (upd_en && m_drop < 65535) m_drop++;
      if (mig_addr_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_drain = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model query_ready", 64'(query_ready), 64'(!m_drain));
      chk("model mig_addr_en", 64'(mig_addr_en), 64'(m_drain));
      chk("model drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (m_drain) chk("model mig_addr", 64'(mig_addr), 64'(mq[0].a));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    started = 1;
  endtask

  task automatic upd(input logic [AW-1:0] a, input logic [CW-1:0] c);
    upd_en = 1'b1;
    upd_addr = a;
    upd_cnt = c;
    @(negedge clk);
    upd_en = 1'b0;
  endtask

  task automatic cmd(input logic [QW-1:0] c);
    query_en = 1'b1;
    query_cmd = c;
    @(negedge clk);
    query_en = 1'b0;
  endtask

  task automatic drain_exp(input string nm, input logic [AW-1:0] exp[$]);
    mig_addr_ready = 1'b1;
    cmd(4'd1);
    foreach (exp[i]) begin
      chk({nm, " en"}, 64'(mig_addr_en), 64'd1);
      chk({nm, " addr"}, 64'(mig_addr), 64'(exp[i]));
      @(negedge clk);
    end
    chk({nm, " end en"}, 64'(mig_addr_en), 64'd0);
    chk({nm, " end ready"}, 64'(query_ready), 64'd1);
    mig_addr_ready = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("reset ready", 64'(query_ready), 64'd1);
    chk("reset en", 64'(mig_addr_en), 64'd0);
    chk("reset addr", 64'(mig_addr), 64'd0);
    chk("reset drop", 64'(drop_cnt), 64'd0);

    // Basic ordering, no-op opcodes.
    upd(28'h10, 13'd5);
    upd(28'h20, 13'd9);
    upd(28'h30, 13'd7);
    cmd(4'd0);
    cmd(4'd7);
    drain_exp("order", '{28'h20, 28'h30, 28'h10});

    // Full table, low update discarded.
    do_reset();
    for (int i = 0; i < 5; i++) upd(28'hA1 + 28'(i), 13'(10 - i));
    upd(28'h99, 13'd6);
    drain_exp("discard",
              '{28'hA1, 28'hA2, 28'hA3, 28'hA4, 28'hA5});

    // Full table, insert after the equal-count entry, evict the tail.
    do_reset();
    for (int i = 0; i < 5; i++) upd(28'hA1 + 28'(i), 13'(10 - i));
    upd(28'h99, 13'd6);
    upd(28'h99, 13'd8);
    drain_exp("evict",
              '{28'hA1, 28'hA2, 28'hA3, 28'h99, 28'hA4});

    // Re-update moves an existing address without duplicating it.
    do_reset();
    upd(28'h10, 13'd5);
    upd(28'h20, 13'd9);
    upd(28'h10, 13'd12);
    drain_exp("promote", '{28'h10, 28'h20});

    // Stalled drain: stable address, drops counted, query ignored.
    do_reset();
    upd(28'h40, 13'd3);
    upd(28'h41, 13'd2);
    upd(28'h42, 13'd1);
    cmd(4'd1);
    for (int i = 0; i < 4; i++) begin
      upd_en = (i < 3);
      upd_addr = 28'h77;
      upd_cnt = 13'd100;
      query_en = (i == 3);
      query_cmd = 4'd2;
      @(negedge clk);
      chk("stall addr", 64'(mig_addr), 64'h40);
      chk("stall ready", 64'(query_ready), 64'd0);
      chk("stall en", 64'(mig_addr_en), 64'd1);
    end
    upd_en = 1'b0;
    query_en = 1'b0;
    chk("stall drop", 64'(drop_cnt), 64'd3);
    mig_addr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall drain", 64'(mig_addr), 64'(28'h40 + 28'(i)));
      @(negedge clk);
    end
    chk("stall end en", 64'(mig_addr_en), 64'd0);
    mig_addr_ready = 1'b0;

    // Flush with a concurrent update, then MIG finds nothing.
    do_reset();
    upd(28'h50, 13'd3);
    upd(28'h51, 13'd2);
    upd(28'h52, 13'd1);
    query_en = 1'b1;
    query_cmd = 4'd2;
    upd_en = 1'b1;
    upd_addr = 28'h55;
    upd_cnt = 13'd20;
    @(negedge clk);
    query_en = 1'b0;
    upd_en = 1'b0;
    cmd(4'd1);
    chk("flush en", 64'(mig_addr_en), 64'd0);
    chk("flush ready", 64'(query_ready), 64'd1);
    chk("flush drop", 64'(drop_cnt), 64'd0);

    // Reset in the middle of a drain.
    do_reset();
    for (int i = 0; i < 4; i++) upd(28'h60 + 28'(i), 13'(4 - i));
    mig_addr_ready = 1'b1;
    cmd(4'd1);
    chk("rstdrain first", 64'(mig_addr), 64'h60);
    @(negedge clk);
    chk("rstdrain second", 64'(mig_addr), 64'h61);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mig_addr_ready = 1'b0;
    chk("rstdrain en", 64'(mig_addr_en), 64'd0);
    chk("rstdrain ready", 64'(query_ready), 64'd1);
    chk("rstdrain addr", 64'(mig_addr), 64'd0);
    cmd(4'd1);
    chk("rstdrain empty", 64'(mig_addr_en), 64'd0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
